dmem_arbiter: RTL and testbench

- Shares the single data memory port between two requesters: the CPU load/store path and an auxiliary port (debug loader / DMA).
- Sits between the cpu, an aux master and dmem inside the computer top level.
- Grants one requester per cycle using round-robin arbitration.
- Supports an aux bus lock with a bounded starvation limit.
- Stalls the CPU when it loses arbitration.

---
 rtl/dmem_arb_pkg.sv | 30 +++
 rtl/dmem_arbiter_rr_pick.sv | 39 +++
 rtl/dmem_arbiter.sv | 128 ++++++++++++
 tb/tb_dmem_arbiter.sv | 354 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_arb_pkg.sv
// Shared types for the data-memory arbiter: arbitration state, grant owner
// and lock counter helpers.
package dmem_arb_pkg;

  localparam int LOCK_W = 8;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    LAST_CPU = 2'd1,
    LAST_AUX = 2'd2,
    LOCKED   = 2'd3
  } arb_state_t;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_CPU  = 2'd1,
    OWN_AUX  = 2'd2
  } owner_t;

  // Saturating increment so a long lock cannot wrap back below the limit.
  function automatic logic [LOCK_W-1:0] lock_inc(input logic [LOCK_W-1:0] cnt,
                                                 input logic [LOCK_W-1:0] lim);
    if (cnt >= lim) begin
      return lim;
    end else begin
      return cnt + 8'd1;
    end
  endfunction

endpackage

// File: rtl/dmem_arbiter_rr_pick.sv
// Combinational grant decision: round-robin between CPU and aux, with a
// bounded aux lock that forces one CPU grant after MAX_LOCK locked grants.
module arb_rr_pick
  import dmem_arb_pkg::*;
#(
  parameter int MAX_LOCK = 8
) (
  input  arb_state_t              state_i,
  input  logic [LOCK_W-1:0]       lock_cnt_i,
  input  logic                    cpu_req_i,
  input  logic                    aux_req_i,
  output owner_t                  owner_o
);

  // Lock only holds while aux keeps requesting; otherwise plain round-robin.
  always_comb begin
    owner_o = OWN_NONE;
    if ((state_i == LOCKED) && aux_req_i) begin
      if (cpu_req_i && (lock_cnt_i >= LOCK_W'(MAX_LOCK))) begin
        owner_o = OWN_CPU;
      end else begin
        owner_o = OWN_AUX;
      end
    end else if (cpu_req_i && aux_req_i) begin
      if (state_i == LAST_CPU) begin
        owner_o = OWN_AUX;
      end else begin
        owner_o = OWN_CPU;
      end
    end else if (cpu_req_i) begin
      owner_o = OWN_CPU;
    end else if (aux_req_i) begin
      owner_o = OWN_AUX;
    end else begin
      owner_o = OWN_NONE;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares one data-memory port between the CPU and an aux master; holds the
// arbitration state, drives the memory mux and registers aux read data.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int n        = 16,
  parameter int MAX_LOCK = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         cpu_req,
  input  logic         cpu_we,
  input  logic [n-1:0] cpu_addr,
  input  logic [n-1:0] cpu_wdata,
  output logic [n-1:0] cpu_rdata,
  output logic         cpu_stall,
  input  logic         aux_req,
  input  logic         aux_we,
  input  logic [n-1:0] aux_addr,
  input  logic [n-1:0] aux_wdata,
  input  logic         aux_lock,
  output logic         aux_gnt,
  output logic [n-1:0] aux_rdata,
  output logic         aux_rvalid,
  output logic         mem_we,
  output logic [n-1:0] mem_addr,
  output logic [n-1:0] mem_wdata,
  input  logic [n-1:0] mem_rdata
);

  arb_state_t        state_q, state_d;
  logic [LOCK_W-1:0] lock_cnt_q, lock_cnt_d;
  logic [n-1:0]      aux_rdata_q, aux_rdata_d;
  logic              aux_rvalid_q, aux_rvalid_d;
  owner_t            owner_s;

  arb_rr_pick #(.MAX_LOCK(MAX_LOCK)) u_pick (
    .state_i    (state_q),
    .lock_cnt_i (lock_cnt_q),
    .cpu_req_i  (cpu_req),
    .aux_req_i  (aux_req),
    .owner_o    (owner_s)
  );

  // Next state and aux read pipeline. Only grants made while already LOCKED
  // count toward the limit, so the unlocked win that starts a lock is free.
  always_comb begin
    state_d      = state_q;
    lock_cnt_d   = lock_cnt_q;
    aux_rdata_d  = aux_rdata_q;
    aux_rvalid_d = 1'b0;
    case (owner_s)
      OWN_CPU: begin
        state_d    = LAST_CPU;
        lock_cnt_d = 8'd0;
      end
      OWN_AUX: begin
        if (aux_lock) begin
          state_d = LOCKED;
          if (state_q == LOCKED) begin
            lock_cnt_d = lock_inc(lock_cnt_q, LOCK_W'(MAX_LOCK));
          end else begin
            lock_cnt_d = 8'd0;
          end
        end else begin
          state_d    = LAST_AUX;
          lock_cnt_d = 8'd0;
        end
        if (!aux_we) begin
          aux_rvalid_d = 1'b1;
          aux_rdata_d  = mem_rdata;
        end else begin
          aux_rvalid_d = 1'b0;
        end
      end
      default: begin
        state_d    = IDLE;
        lock_cnt_d = 8'd0;
      end
    endcase
  end

  // Memory port mux; an idle port drives zeros so mem_we needs a grant.
  always_comb begin
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    case (owner_s)
      OWN_CPU: begin
        mem_we    = cpu_we;
        mem_addr  = cpu_addr;
        mem_wdata = cpu_wdata;
      end
      OWN_AUX: begin
        mem_we    = aux_we;
        mem_addr  = aux_addr;
        mem_wdata = aux_wdata;
      end
      default: begin
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
      end
    endcase
  end

  assign cpu_rdata  = mem_rdata;
  assign cpu_stall  = cpu_req & (owner_s != OWN_CPU);
  assign aux_gnt    = (owner_s == OWN_AUX);
  assign aux_rdata  = aux_rdata_q;
  assign aux_rvalid = aux_rvalid_q;

  // State registers; reset favours the CPU on the first tie.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= LAST_AUX;
      lock_cnt_q   <= 8'd0;
      aux_rdata_q  <= '0;
      aux_rvalid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      lock_cnt_q   <= lock_cnt_d;
      aux_rdata_q  <= aux_rdata_d;
      aux_rvalid_q <= aux_rvalid_d;
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: directed scenarios plus random
// traffic compared against a grant-history reference model.
module tb_dmem_arbiter;

  localparam int N  = 16;
  localparam int ML = 3;

  logic         clk = 1'b0;
  logic         reset;
  logic         cpu_req, cpu_we, aux_req, aux_we, aux_lock;
  logic [N-1:0] cpu_addr, cpu_wdata, aux_addr, aux_wdata;
  logic [N-1:0] cpu_rdata, aux_rdata, mem_addr, mem_wdata, mem_rdata;
  logic         cpu_stall, aux_gnt, aux_rvalid, mem_we;

  logic [N-1:0] mem_arr [256];

  int vectors     = 0;
  int miscompares = 0;

  // reference model: who won last, whether a lock is running, locked grants so far
  int           m_last;
  bit           m_locked;
  int           m_run;
  logic         m_rvalid;
  logic [N-1:0] m_rdata;

  int           e_own;
  logic         e_we, e_stall, e_gnt;
  logic [N-1:0] e_addr, e_wdata, e_cpu_rdata;

  dmem_arbiter #(.n(N), .MAX_LOCK(ML)) dut (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
    .aux_req(aux_req), .aux_we(aux_we), .aux_addr(aux_addr), .aux_wdata(aux_wdata),
    .aux_lock(aux_lock), .aux_gnt(aux_gnt), .aux_rdata(aux_rdata), .aux_rvalid(aux_rvalid),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  assign mem_rdata = mem_arr[mem_addr[8:1]];

  always @(posedge clk) begin
    if (mem_we) mem_arr[mem_addr[8:1]] <= mem_wdata;
  end

  task automatic model_reset();
    m_last   = 2;
    m_locked = 1'b0;
    m_run    = 0;
    m_rvalid = 1'b0;
    m_rdata  = '0;
  endtask

  task automatic model_eval();
    if (m_locked && aux_req) begin
      e_own = (cpu_req && m_run >= ML) ? 1 : 2;
    end else if (cpu_req && aux_req) begin
      e_own = (m_last == 1) ? 2 : 1;
    end else if (cpu_req) begin
      e_own = 1;
    end else if (aux_req) begin
      e_own = 2;
    end else begin
      e_own = 0;
    end
    e_we    = (e_own == 1) ? cpu_we : (e_own == 2) ? aux_we : 1'b0;
    e_addr  = (e_own == 1) ? cpu_addr : (e_own == 2) ? aux_addr : 16'h0000;
    e_wdata = (e_own == 1) ? cpu_wdata : (e_own == 2) ? aux_wdata : 16'h0000;
    e_stall = cpu_req && (e_own != 1);
    e_gnt   = (e_own == 2);
    e_cpu_rdata = mem_arr[e_addr[8:1]];
  endtask

  task automatic model_commit();
    logic [N-1:0] rd;
    rd = mem_arr[aux_addr[8:1]];
    if (e_own == 2 && !aux_we) begin
      m_rvalid = 1'b1;
      m_rdata  = rd;
    end else begin
      m_rvalid = 1'b0;
    end
    if (e_own == 1) begin
      m_last = 1; m_locked = 1'b0; m_run = 0;
    end else if (e_own == 2) begin
      m_last = 2;
      if (aux_lock) begin
        m_run    = m_locked ? ((m_run + 1 > ML) ? ML : m_run + 1) : 0;
        m_locked = 1'b1;
      end else begin
        m_locked = 1'b0; m_run = 0;
      end
    end else begin
      m_last = 0; m_locked = 1'b0; m_run = 0;
    end
  endtask

  task automatic idle_inputs();
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    aux_req = 1'b0; aux_we = 1'b0; aux_addr = '0; aux_wdata = '0; aux_lock = 1'b0;
  endtask

  task automatic tick();
    model_commit();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    idle_inputs();
    reset = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 1'b0;
    model_reset();
    @(negedge clk);
    vectors++;
    if (aux_rvalid !== 1'b0 || aux_rdata !== 16'h0000) begin
      miscompares++;
      $display("FAIL reset_aux: rvalid=%b rdata=%h, want 0/0000", aux_rvalid, aux_rdata);
    end
    vectors++;
    if (mem_we !== 1'b0 || cpu_stall !== 1'b0 || aux_gnt !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_idle: mem_we=%b stall=%b gnt=%b, want 0/0/0", mem_we, cpu_stall, aux_gnt);
    end
    @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  task automatic test_cpu_write();
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 16'h0004; cpu_wdata = 16'h1234;
    @(negedge clk);
    model_eval();
    vectors++;
    if (mem_we !== 1'b1 || mem_addr !== 16'h0004 || mem_wdata !== 16'h1234) begin
      miscompares++;
      $display("FAIL cpu_write_mux: we=%b addr=%h wdata=%h, want 1/0004/1234", mem_we, mem_addr, mem_wdata);
    end
    vectors++;
    if (cpu_stall !== 1'b0 || aux_gnt !== 1'b0) begin
      miscompares++;
      $display("FAIL cpu_write_gnt: stall=%b gnt=%b, want 0/0", cpu_stall, aux_gnt);
    end
    tick();
    idle_inputs();
    @(negedge clk);
    vectors++;
    if (mem_arr[2] !== 16'h1234) begin
      miscompares++;
      $display("FAIL cpu_write_mem: mem[4]=%h, want 1234", mem_arr[2]);
    end
    model_eval();
    tick();
  endtask

  task automatic test_alternation();
    logic exp_g [3];
    exp_g[0] = 1'b0; exp_g[1] = 1'b1; exp_g[2] = 1'b0;
    apply_reset();
    cpu_req = 1'b1; aux_req = 1'b1; aux_we = 1'b1; cpu_addr = 16'h0020; aux_addr = 16'h0030;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      model_eval();
      vectors++;
      if (aux_gnt !== exp_g[i] || cpu_stall !== exp_g[i] || aux_gnt !== e_gnt) begin
        miscompares++;
        $display("FAIL alternation[%0d]: gnt=%b stall=%b, want %b/%b", i, aux_gnt, cpu_stall, exp_g[i], exp_g[i]);
      end
      tick();
    end
    idle_inputs();
  endtask

  task automatic test_aux_read();
    mem_arr[8] = 16'hBEEF;
    aux_req = 1'b1; aux_we = 1'b0; aux_addr = 16'h0010;
    @(negedge clk);
    model_eval();
    vectors++;
    if (aux_gnt !== 1'b1 || mem_addr !== 16'h0010 || mem_we !== 1'b0) begin
      miscompares++;
      $display("FAIL aux_read_gnt: gnt=%b addr=%h we=%b, want 1/0010/0", aux_gnt, mem_addr, mem_we);
    end
    tick();
    idle_inputs();
    @(negedge clk);
    model_eval();
    vectors++;
    if (aux_rvalid !== 1'b1 || aux_rdata !== 16'hBEEF) begin
      miscompares++;
      $display("FAIL aux_read_data: rvalid=%b rdata=%h, want 1/beef", aux_rvalid, aux_rdata);
    end
    tick();
    @(negedge clk);
    model_eval();
    vectors++;
    if (aux_rvalid !== 1'b0 || aux_rdata !== 16'hBEEF) begin
      miscompares++;
      $display("FAIL aux_read_drop: rvalid=%b rdata=%h, want 0/beef", aux_rvalid, aux_rdata);
    end
    tick();
  endtask

  task automatic test_lock_limit();
    logic exp_g [6];
    exp_g[0] = 1'b1; exp_g[1] = 1'b1; exp_g[2] = 1'b1;
    exp_g[3] = 1'b1; exp_g[4] = 1'b0; exp_g[5] = 1'b1;
    cpu_req = 1'b1; cpu_addr = 16'h0040;
    @(negedge clk);
    model_eval();
    tick();
    aux_req = 1'b1; aux_lock = 1'b1; aux_we = 1'b1; aux_addr = 16'h0050; aux_wdata = 16'h5A5A;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      model_eval();
      vectors++;
      if (aux_gnt !== exp_g[i] || cpu_stall !== exp_g[i]) begin
        miscompares++;
        $display("FAIL lock_limit[%0d]: gnt=%b stall=%b, want %b/%b", i, aux_gnt, cpu_stall, exp_g[i], exp_g[i]);
      end
      tick();
    end
  endtask

  task automatic test_lock_release();
    aux_lock = 1'b0;
    @(negedge clk);
    model_eval();
    vectors++;
    if (aux_gnt !== 1'b1) begin
      miscompares++;
      $display("FAIL release_last_aux: gnt=%b, want 1", aux_gnt);
    end
    tick();
    aux_lock = 1'b1;
    @(negedge clk);
    model_eval();
    vectors++;
    if (aux_gnt !== 1'b0 || cpu_stall !== 1'b0) begin
      miscompares++;
      $display("FAIL release_cpu: gnt=%b stall=%b, want 0/0", aux_gnt, cpu_stall);
    end
    tick();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      model_eval();
      vectors++;
      if (aux_gnt !== 1'b1) begin
        miscompares++;
        $display("FAIL release_cnt_cleared[%0d]: gnt=%b, want 1", i, aux_gnt);
      end
      tick();
    end
    idle_inputs();
  endtask

  task automatic test_reset_mid_lock();
    aux_req = 1'b1; aux_lock = 1'b1; aux_we = 1'b0; aux_addr = 16'h0010;
    @(negedge clk);
    model_eval();
    tick();
    @(negedge clk);
    model_eval();
    tick();
    idle_inputs();
    reset = 1'b0;
    model_reset();
    #1;
    vectors++;
    if (aux_rvalid !== 1'b0 || mem_we !== 1'b0 || aux_gnt !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_mid_lock: rvalid=%b mem_we=%b gnt=%b, want 0/0/0", aux_rvalid, mem_we, aux_gnt);
    end
    @(posedge clk);
    #1;
    reset = 1'b1;
    cpu_req = 1'b1; aux_req = 1'b1; aux_lock = 1'b1; aux_we = 1'b1;
    @(negedge clk);
    model_eval();
    vectors++;
    if (aux_gnt !== 1'b0 || cpu_stall !== 1'b0) begin
      miscompares++;
      $display("FAIL post_reset_tie: gnt=%b stall=%b, want 0/0", aux_gnt, cpu_stall);
    end
    tick();
    idle_inputs();
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      cpu_req   = ($urandom_range(0, 3) != 0);
      cpu_we    = $urandom_range(0, 1) != 0;
      cpu_addr  = 16'($urandom);
      cpu_wdata = 16'($urandom);
      aux_req   = ($urandom_range(0, 3) != 0);
      aux_we    = $urandom_range(0, 1) != 0;
      aux_addr  = 16'($urandom);
      aux_wdata = 16'($urandom);
      aux_lock  = ($urandom_range(0, 4) != 0);
      @(negedge clk);
      model_eval();
      vectors++;
      if (aux_gnt !== e_gnt || cpu_stall !== e_stall) begin
        miscompares++;
        $display("FAIL rand_grant[%0d]: gnt=%b stall=%b, want %b/%b", i, aux_gnt, cpu_stall, e_gnt, e_stall);
      end
      vectors++;
      if (mem_we !== e_we || mem_addr !== e_addr || mem_wdata !== e_wdata) begin
        miscompares++;
        $display("FAIL rand_mux[%0d]: we=%b addr=%h wdata=%h, want %b/%h/%h", i, mem_we, mem_addr, mem_wdata, e_we, e_addr, e_wdata);
      end
      vectors++;
      if (cpu_rdata !== e_cpu_rdata) begin
        miscompares++;
        $display("FAIL rand_cpu_rdata[%0d]: got %h, want %h", i, cpu_rdata, e_cpu_rdata);
      end
      vectors++;
      if (aux_rvalid !== m_rvalid || aux_rdata !== m_rdata) begin
        miscompares++;
        $display("FAIL rand_aux_rd[%0d]: rvalid=%b rdata=%h, want %b/%h", i, aux_rvalid, aux_rdata, m_rvalid, m_rdata);
      end
      tick();
    end
    idle_inputs();
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem_arr[i] = 16'($urandom);
    idle_inputs();
    reset = 1'b1;
    #2;
    test_reset();
    test_cpu_write();
    test_alternation();
    test_aux_read();
    test_lock_limit();
    test_lock_release();
    test_reset_mid_lock();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
